// File: rtl/scaler_div_arbiter_if.sv
// Request/response bundle between the v/h cfggen phase machines and the shared
// 2^17/divisor unit; the arbiter takes the slave side.
interface scaler_div_arbiter_if #(
  parameter int DIVIDEND_WIDTH = 18,
  parameter int DIVISOR_WIDTH  = 12
);

  logic                      v_req_i;
  logic [DIVISOR_WIDTH-1:0]  v_divisor_i;
  logic                      v_ack_o;
  logic                      v_busy_o;
  logic                      v_done_o;
  logic [DIVIDEND_WIDTH-1:0] v_quotient_o;

  logic                      h_req_i;
  logic [DIVISOR_WIDTH-1:0]  h_divisor_i;
  logic                      h_ack_o;
  logic                      h_busy_o;
  logic                      h_done_o;
  logic [DIVIDEND_WIDTH-1:0] h_quotient_o;

  logic                      arb_busy_o;

  modport master (
    output v_req_i, v_divisor_i, h_req_i, h_divisor_i,
    input  v_ack_o, v_busy_o, v_done_o, v_quotient_o,
    input  h_ack_o, h_busy_o, h_done_o, h_quotient_o,
    input  arb_busy_o
  );

  modport slave (
    input  v_req_i, v_divisor_i, h_req_i, h_divisor_i,
    output v_ack_o, v_busy_o, v_done_o, v_quotient_o,
    output h_ack_o, h_busy_o, h_done_o, h_quotient_o,
    output arb_busy_o
  );

endinterface

// File: rtl/scaler_div_arbiter.sv
// One restoring serial divider computing 2^(DIVIDEND_WIDTH-1)/divisor, shared
// round-robin between the vertical and horizontal scaler cfggen paths.
module scaler_div_arbiter #(
  parameter int DIVIDEND_WIDTH = 18,
  parameter int DIVISOR_WIDTH  = 12
) (
  input logic                 SYS_CLK,
  input logic                 nRST,
  scaler_div_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(DIVIDEND_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDEND_WIDTH - 1);
  localparam logic [DIVIDEND_WIDTH-1:0] DIVIDEND_INIT = {1'b1, {(DIVIDEND_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
  typedef enum logic {CH_V = 1'b0, CH_H = 1'b1} chan_t;

  state_t state;
  state_t state_next;
  chan_t  sel;
  chan_t  last_grant;
  chan_t  grant_ch;
  logic   grant_valid;

  logic [DIVISOR_WIDTH-1:0]  grant_div;
  logic [DIVISOR_WIDTH-1:0]  div_reg;
  logic [DIVIDEND_WIDTH-1:0] dvd_sh;
  logic [DIVISOR_WIDTH:0]    rem_reg;
  logic [DIVIDEND_WIDTH-2:0] quo_sh;
  logic [CNT_W-1:0]          cnt;
  logic [DIVIDEND_WIDTH-1:0] v_quo;
  logic [DIVIDEND_WIDTH-1:0] h_quo;

  logic [DIVISOR_WIDTH+1:0]  trial;
  logic [DIVISOR_WIDTH:0]    rem_sub;
  logic [DIVISOR_WIDTH:0]    rem_next;
  logic                      take;
  logic [DIVIDEND_WIDTH-1:0] quo_next;

  // On a tie the channel that was not served last wins.
  always_comb begin
    grant_valid = bus.v_req_i | bus.h_req_i;
    grant_ch    = CH_V;
    if (bus.v_req_i && bus.h_req_i)
      grant_ch = (last_grant == CH_V) ? CH_H : CH_V;
    else if (bus.h_req_i)
      grant_ch = CH_H;
    grant_div = (grant_ch == CH_H) ? bus.h_divisor_i : bus.v_divisor_i;
  end

  // A zero divisor passes every trial, so the quotient saturates to all-ones.
  always_comb begin
    trial    = {rem_reg, dvd_sh[DIVIDEND_WIDTH-1]};
    take     = (trial >= {2'b00, div_reg});
    rem_sub  = trial[DIVISOR_WIDTH:0] - {1'b0, div_reg};
    rem_next = take ? rem_sub : trial[DIVISOR_WIDTH:0];
    quo_next = {quo_sh, take};
  end

  always_ff @(posedge SYS_CLK or negedge nRST) begin
    if (!nRST)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_valid) state_next = CALC;
      CALC:    if (cnt == '0) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The result is committed on the last iteration so it is already visible
  // in the FIN cycle alongside the done pulse.
  always_ff @(posedge SYS_CLK or negedge nRST) begin
    if (!nRST) begin
      div_reg    <= '0;
      dvd_sh     <= '0;
      rem_reg    <= '0;
      quo_sh     <= '0;
      cnt        <= '0;
      sel        <= CH_V;
      last_grant <= CH_H;
      v_quo      <= '0;
      h_quo      <= '0;
    end else if (state == IDLE) begin
      if (grant_valid) begin
        div_reg    <= grant_div;
        dvd_sh     <= DIVIDEND_INIT;
        rem_reg    <= '0;
        quo_sh     <= '0;
        cnt        <= CNT_LAST;
        sel        <= grant_ch;
        last_grant <= grant_ch;
      end
    end else if (state == CALC) begin
      rem_reg <= rem_next;
      dvd_sh  <= {dvd_sh[DIVIDEND_WIDTH-2:0], 1'b0};
      quo_sh  <= quo_next[DIVIDEND_WIDTH-2:0];
      cnt     <= cnt - CNT_W'(1);
      if (cnt == '0) begin
        if (sel == CH_V)
          v_quo <= quo_next;
        else
          h_quo <= quo_next;
      end
    end
  end

  // The ack lands on the first CALC cycle, the only one with a full count.
  always_comb begin
    bus.v_ack_o      = (state == CALC) && (cnt == CNT_LAST) && (sel == CH_V);
    bus.h_ack_o      = (state == CALC) && (cnt == CNT_LAST) && (sel == CH_H);
    bus.v_busy_o     = (state != IDLE) && (sel == CH_V);
    bus.h_busy_o     = (state != IDLE) && (sel == CH_H);
    bus.v_done_o     = (state == FIN) && (sel == CH_V);
    bus.h_done_o     = (state == FIN) && (sel == CH_H);
    bus.v_quotient_o = v_quo;
    bus.h_quotient_o = h_quo;
    bus.arb_busy_o   = (state != IDLE);
  end

endmodule

// File: tb/tb_scaler_div_arbiter.sv
// Randomised scoreboard bench for scaler_div_arbiter: jobs push 2^17/divisor
// into per-channel queues, a monitor pops them on each done pulse.
module tb_scaler_div_arbiter;

  localparam int DW = 18;
  localparam int SW = 12;

  logic SYS_CLK = 1'b0;
  logic nRST;

  always #5 SYS_CLK = ~SYS_CLK;

  scaler_div_arbiter_if #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(SW)) bus ();

  scaler_div_arbiter #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(SW)) dut (
    .SYS_CLK(SYS_CLK),
    .nRST   (nRST),
    .bus    (bus)
  );

  int checks;
  int failures;
  int cyc;
  logic [DW-1:0] exp_v[$];
  logic [DW-1:0] exp_h[$];
  int v_rd;
  int h_rd;
  logic [DW-1:0] model_v;
  logic [DW-1:0] model_h;
  int v_ack_cyc;
  int h_ack_cyc;
  bit last_served;

  function automatic logic [DW-1:0] ref_quot(input int d);
    if (d == 0) return '1;
    return DW'((1 << (DW - 1)) / d);
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s at t=%0t", name, $time);
  endtask

  // Scoreboard side: every done must match the oldest outstanding job.
  task automatic monitor_loop();
    forever begin
      @(negedge SYS_CLK);
      cyc++;
      if (!nRST) begin
        v_rd    = exp_v.size();
        h_rd    = exp_h.size();
        model_v = '0;
        model_h = '0;
        check_output("reset_flags", {bus.v_ack_o, bus.v_busy_o, bus.v_done_o, bus.h_ack_o,
                     bus.h_busy_o, bus.h_done_o, bus.arb_busy_o}, 0);
        check_output("reset_quotients", {bus.v_quotient_o | bus.h_quotient_o}, 0);
      end else begin
        if (bus.v_ack_o || bus.h_ack_o) check_output("ack_exclusive", bus.v_ack_o & bus.h_ack_o, 0);
        if (bus.v_done_o || bus.h_done_o) check_output("done_exclusive", bus.v_done_o & bus.h_done_o, 0);
        if (bus.v_ack_o) v_ack_cyc = cyc;
        if (bus.h_ack_o) h_ack_cyc = cyc;
        if (bus.v_done_o) begin
          if (v_rd < exp_v.size()) begin
            model_v = exp_v[v_rd];
            v_rd++;
            check_output("v_quotient", bus.v_quotient_o, model_v);
            check_output("v_ack_to_done", cyc - v_ack_cyc, 18);
          end else flag_fail("v_done_unexpected");
        end else check_output("v_quotient_held", bus.v_quotient_o, model_v);
        if (bus.h_done_o) begin
          if (h_rd < exp_h.size()) begin
            model_h = exp_h[h_rd];
            h_rd++;
            check_output("h_quotient", bus.h_quotient_o, model_h);
            check_output("h_ack_to_done", cyc - h_ack_cyc, 18);
          end else flag_fail("h_done_unexpected");
        end else check_output("h_quotient_held", bus.h_quotient_o, model_h);
      end
    end
  endtask

  // Holds req until the requested number of acks, then drops it.
  task automatic apply_stimulus(input bit ch, input int d, input int reps, output int ack_wait);
    int acks;
    acks = 0;
    ack_wait = -1;
    @(posedge SYS_CLK); #1;
    if (ch == 1'b0) begin
      bus.v_divisor_i = SW'(d);
      bus.v_req_i     = 1'b1;
      for (int r = 0; r < reps; r++) exp_v.push_back(ref_quot(d));
    end else begin
      bus.h_divisor_i = SW'(d);
      bus.h_req_i     = 1'b1;
      for (int r = 0; r < reps; r++) exp_h.push_back(ref_quot(d));
    end
    for (int k = 1; k <= 100 && acks < reps; k++) begin
      @(negedge SYS_CLK);
      if ((ch == 1'b0 && bus.v_ack_o) || (ch == 1'b1 && bus.h_ack_o)) begin
        acks++;
        if (acks == 1) ack_wait = k - 1;
      end
    end
    if (ch == 1'b0) bus.v_req_i = 1'b0;
    else            bus.h_req_i = 1'b0;
    check_output(ch ? "h_ack_count" : "v_ack_count", acks, reps);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge SYS_CLK);
      if (v_rd == exp_v.size() && h_rd == exp_h.size() && !bus.arb_busy_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) flag_fail("wait_idle_timeout");
  endtask

  task automatic do_reset();
    @(negedge SYS_CLK);
    nRST = 1'b0;
    repeat (2) @(negedge SYS_CLK);
    nRST = 1'b1;
    last_served = 1'b1;
  endtask

  task automatic single_job(input bit ch, input int d);
    int w;
    apply_stimulus(ch, d, 1, w);
    check_output(ch ? "h_ack_latency" : "v_ack_latency", w, 1);
    check_output("busy_during_job", {bus.v_busy_o, bus.h_busy_o, bus.arb_busy_o},
                 ch ? 3'b011 : 3'b101);
    last_served = ch;
    wait_idle();
  endtask

  // Simultaneous requests: the channel not served last goes first.
  task automatic pair_job(input int dv, input int dh);
    int wv;
    int wh;
    fork
      apply_stimulus(1'b0, dv, 1, wv);
      apply_stimulus(1'b1, dh, 1, wh);
    join
    if (last_served == 1'b1) begin
      check_output("pair_v_first_ack", wv, 1);
      check_output("pair_h_second_ack", wh, 21);
      last_served = 1'b1;
    end else begin
      check_output("pair_h_first_ack", wh, 1);
      check_output("pair_v_second_ack", wv, 21);
      last_served = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    int w;
    int cnt;
    checks = 0; failures = 0; cyc = 0;
    v_rd = 0; h_rd = 0; model_v = '0; model_h = '0;
    v_ack_cyc = 0; h_ack_cyc = 0; last_served = 1'b1;
    bus.v_req_i = 1'b0; bus.v_divisor_i = '0;
    bus.h_req_i = 1'b0; bus.h_divisor_i = '0;
    nRST = 1'b1;
    #2 nRST = 1'b0;
    fork
      monitor_loop();
    join_none
    repeat (3) @(negedge SYS_CLK);
    nRST = 1'b1;
    @(negedge SYS_CLK);
    check_output("idle_after_reset", bus.arb_busy_o, 0);

    single_job(1'b0, 480);
    single_job(1'b1, 1280);
    single_job(1'b1, 1920);

    do_reset();
    pair_job(720, 1280);
    single_job(1'b0, 100);
    pair_job(300, 600);

    single_job(1'b0, 0);
    single_job(1'b1, 1);
    single_job(1'b0, 4095);

    // Reset in the middle of CALC aborts the job without a done.
    apply_stimulus(1'b0, 480, 1, w);
    repeat (5) @(posedge SYS_CLK);
    #2 nRST = 1'b0;
    #1;
    check_output("async_reset_flags", {bus.v_ack_o, bus.v_busy_o, bus.v_done_o, bus.h_ack_o,
                 bus.h_busy_o, bus.h_done_o, bus.arb_busy_o}, 0);
    check_output("async_reset_quotients", {bus.v_quotient_o | bus.h_quotient_o}, 0);
    repeat (2) @(negedge SYS_CLK);
    nRST = 1'b1;
    last_served = 1'b1;
    cnt = 0;
    repeat (25) begin
      @(negedge SYS_CLK);
      if (bus.v_done_o || bus.h_done_o) cnt++;
    end
    check_output("no_done_after_reset", cnt, 0);
    single_job(1'b1, 1920);

    // One-cycle pulse while the divider is busy must be dropped.
    apply_stimulus(1'b0, 1280, 1, w);
    last_served = 1'b0;
    @(posedge SYS_CLK); #1;
    bus.h_divisor_i = SW'(7);
    bus.h_req_i = 1'b1;
    @(posedge SYS_CLK); #1;
    bus.h_req_i = 1'b0;
    cnt = 0;
    repeat (25) begin
      @(negedge SYS_CLK);
      if (bus.h_ack_o || bus.h_busy_o) cnt++;
    end
    check_output("pulsed_req_ignored", cnt, 0);
    wait_idle();

    // Request held through completion yields a second job.
    apply_stimulus(1'b0, 300, 2, w);
    check_output("held_req_first_ack", w, 1);
    last_served = 1'b0;
    wait_idle();

    for (int i = 0; i < 25; i++) begin
      int mode;
      int dv;
      int dh;
      mode = $urandom_range(0, 2);
      dv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(1, 4095);
      dh = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(1, 4095);
      if (mode == 0)      single_job(1'b0, dv);
      else if (mode == 1) single_job(1'b1, dh);
      else                pair_job(dv, dh);
    end

    wait_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
